// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-cycle adder/subtractor.
package adder_pkg;

  // Control FSM states; exposed on the top level for observation.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation select encoding on the mode input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple row built from full_adder cells.
// Also reports the carry into the row MSB so the caller can form signed overflow.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multi_cycle_adder.sv
// WIDTH-bit adder/subtractor that processes CHUNK bits per clock, keeping the
// inter-chunk carry in a register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE (and never during reset); in_valid is
// ignored otherwise and nothing is buffered. out_valid stays high in DONE, with
// sum/carry/overflow held, until out_ready is seen; it is never withdrawn early.
module multi_cycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output state_t           fsm_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = $clog2(NCHUNK) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_co;
  logic             chunk_c_msb;

  // Select the operand chunk addressed by the current index.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        a_c = op_a[i*CHUNK +: CHUNK];
        b_c = op_b[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_c),
    .b     (b_c),
    .ci    (carry_reg),
    .s     (chunk_sum),
    .co    (chunk_co),
    .c_msb (chunk_c_msb)
  );

  // Control FSM plus operand, carry and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      carry_reg   <= 1'b0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1; cin only matters for add.
            op_a      <= a;
            op_b      <= (mode == MODE_SUB) ? ~b : b;
            carry_reg <= (mode == MODE_SUB) ? 1'b1 : cin;
            idx       <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) sum_r[i*CHUNK +: CHUNK] <= chunk_sum;
          end
          carry_reg <= chunk_co;
          if (idx == LAST_IDX) begin
            carry_r     <= chunk_co;
            ovf_r       <= chunk_co ^ chunk_c_msb;
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (state == ST_IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign carry     = carry_r;
  assign overflow  = ovf_r;
  assign fsm_state = state;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed and random checks of multi_cycle_adder in the 32/8 and 8/8 configurations.
module tb_multi_cycle_adder;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT 32/8 ----------------
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, mode = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        out_valid, out_ready = 1'b0, carry, overflow;
  state_t      st;

  multi_cycle_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow),
    .fsm_state(st)
  );

  // ---------------- DUT 8/8 ----------------
  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       out_valid8, out_ready8 = 1'b0, carry8, overflow8;
  state_t     st8;

  multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .mode(mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .carry(carry8), .overflow(overflow8),
    .fsm_state(st8)
  );

  // ---------------- scoreboard ----------------
  int test_cnt = 0;
  int fail_cnt = 0;
  logic [33:0] exp_q[$];   // {overflow, carry, sum}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: returns {overflow, carry, sum} for a WIDTH-bit op.
  function automatic logic [33:0] ref32(input logic [31:0] ra, input logic [31:0] rb,
                                        input logic rc, input logic rm);
    logic [32:0] full;
    logic [31:0] r;
    logic        c, v;
    if (rm == MODE_ADD) begin
      full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      r = full[31:0];
      c = full[32];
      v = (ra[31] == rb[31]) && (r[31] != ra[31]);
    end else begin
      r = ra - rb;
      c = (ra >= rb);
      v = (ra[31] != rb[31]) && (r[31] != ra[31]);
    end
    return {v, c, r};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] ra, input logic [7:0] rb,
                                      input logic rc, input logic rm);
    logic [8:0] full;
    logic [7:0] r;
    logic       c, v;
    if (rm == MODE_ADD) begin
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      r = full[7:0];
      c = full[8];
      v = (ra[7] == rb[7]) && (r[7] != ra[7]);
    end else begin
      r = ra - rb;
      c = (ra >= rb);
      v = (ra[7] != rb[7]) && (r[7] != ra[7]);
    end
    return {v, c, r};
  endfunction

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic start32(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic tm, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    a = ta; b = tb_v; cin = tc; mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom_range(0, 1); mode = $urandom_range(0, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    lat = out_valid ? n : -1;
  endtask

  task automatic finish32();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic start8(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic tm, output int lat);
    int n;
    n = 0;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    a8 = ta; b8 = tb_v; cin8 = tc; mode8 = tm; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin @(posedge clk); #1; n++; end
    lat = out_valid8 ? n : -1;
  endtask

  task automatic finish8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic check32(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_carry"}, 64'(carry), 64'(ec));
    check({tag, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [33:0] e32;
    logic [9:0]  e8;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;
    logic        rc, rm;

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_state", 64'(st), 64'(ST_IDLE));
    check("rst8_out_valid", 64'(out_valid8), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel8_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;

    // 1: all-ones + 1 wraps with carry, latency 4
    start32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, lat);
    check("t1_latency", 64'(lat), 64'd4);
    check32("t1", 32'h0000_0000, 1'b1, 1'b0);
    check("t1_in_ready_done", 64'(in_ready), 64'd0);
    finish32();
    check("t1_out_valid_after", 64'(out_valid), 64'd0);
    check("t1_in_ready_after", 64'(in_ready), 64'd1);

    // 2: signed overflow into the sign bit
    start32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, lat);
    check("t2_latency", 64'(lat), 64'd4);
    check32("t2", 32'h8000_0000, 1'b0, 1'b1);
    finish32();

    // 3: subtract with borrow, cin ignored; then without borrow
    start32(32'd5, 32'd7, 1'b1, MODE_SUB, lat);
    check32("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0);
    finish32();
    start32(32'd7, 32'd5, 1'b0, MODE_SUB, lat);
    check32("t3b", 32'h0000_0002, 1'b1, 1'b0);
    finish32();

    // add with cin=1 carried through chunk boundaries
    start32(32'h00FF_FFFF, 32'h0000_0000, 1'b1, MODE_ADD, lat);
    check32("cin_ripple", 32'h0100_0000, 1'b0, 1'b0);
    finish32();

    // 4: backpressure in DONE, ignored in_valid pulse
    start32(32'h1234_5678, 32'h1111_1111, 1'b1, MODE_ADD, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 32'd1; b = 32'd1; cin = 1'b0; mode = MODE_ADD; in_valid = 1'b1; end
      else in_valid = 1'b0;
      check32("t4_hold", 32'h2345_678A, 1'b0, 1'b0);
      check("t4_in_ready", 64'(in_ready), 64'd0);
      check("t4_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    finish32();
    repeat (3) begin
      check("t4_no_accept_valid", 64'(out_valid), 64'd0);
      check("t4_no_accept_state", 64'(st), 64'(ST_IDLE));
      check("t4_sum_held", 64'(sum), 64'h2345_678A);
      @(posedge clk); #1;
    end

    // 5: reset while index==2 aborts the operation
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; mode = MODE_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_state_run", 64'(st), 64'(ST_RUN));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_sum", 64'(sum), 64'd0);
    check("t5_in_ready_rst", 64'(in_ready), 64'd0);
    check("t5_state", 64'(st), 64'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    check("t5_in_ready_rel", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    start32(32'd1, 32'd1, 1'b0, MODE_ADD, lat);
    check("t5_latency", 64'(lat), 64'd4);
    check32("t5_after", 32'd2, 1'b0, 1'b0);
    finish32();

    // 6: single-chunk configuration
    start8(8'hAA, 8'h55, 1'b1, MODE_ADD, lat);
    check("t6_latency", 64'(lat), 64'd1);
    check("t6_sum", 64'(sum8), 64'h00);
    check("t6_carry", 64'(carry8), 64'd1);
    check("t6_ovf", 64'(overflow8), 64'd0);
    finish8();
    start8(8'h80, 8'h01, 1'b0, MODE_SUB, lat);
    check("t6_sub_ovf", 64'({overflow8, carry8, sum8}), 64'({1'b1, 1'b1, 8'h7F}));
    finish8();

    // 6: random sweep on the 8-bit configuration through the expected queue
    for (int i = 0; i < 300; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom);
      rc = 1'($urandom_range(0, 1)); rm = 1'($urandom_range(0, 1));
      if (i < 4) begin ra8 = {8{i[0]}}; rb8 = {8{i[1]}}; end
      exp_q.push_back(34'(ref8(ra8, rb8, rc, rm)));
      start8(ra8, rb8, rc, rm, lat);
      check("sweep8_valid", 64'(out_valid8), 64'd1);
      e8 = 10'(exp_q.pop_front());
      check("sweep8_result", 64'({overflow8, carry8, sum8}), 64'(e8));
      finish8();
    end

    // random sweep on the 32/8 configuration
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rm = 1'($urandom_range(0, 1));
      exp_q.push_back(ref32(ra, rb, rc, rm));
      start32(ra, rb, rc, rm, lat);
      check("sweep32_latency", 64'(lat), 64'd4);
      e32 = exp_q.pop_front();
      check("sweep32_result", 64'({overflow, carry, sum}), 64'(e32));
      finish32();
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
